// File: rtl/data_memory_responder.sv
// Word-organised data memory answering each load/store after a fixed LATENCY with stall/ack handshake.
// Define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses (err_o); otherwise low address bits are ignored.
module data_memory_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            write_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            mis_q;
    logic            mis_in;
    logic            enter_ack;
    logic            acc_write;
    logic            acc_mis;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic [31:0]     mem [DEPTH];
    logic            unused_addr;

    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_in = (addr_i[1:0] != 2'b00);
`else
    assign mis_in = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_o    = 1'b0;
        case (state)
            IDLE: begin
                busy_o = req_i;
                if (req_i) begin
                    cnt_nxt   = 4'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? ACK : WAIT;
                end
            end
            WAIT: begin
                busy_o  = 1'b1;
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = ACK;
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the ACK-entry edge is also the acceptance edge, so use the live inputs.
    assign enter_ack = (state_nxt == ACK);
    assign acc_write = (state == IDLE) ? write_i     : write_q;
    assign acc_idx   = (state == IDLE) ? addr_i[AW+1:2] : idx_q;
    assign acc_wdata = (state == IDLE) ? data_i      : wdata_q;
    assign acc_mis   = (state == IDLE) ? mis_in      : mis_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            mis_q   <= 1'b0;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            data_o  <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_i) begin
                write_q <= write_i;
                idx_q   <= addr_i[AW+1:2];
                wdata_q <= data_i;
                mis_q   <= mis_in;
            end
            ack_o <= enter_ack;
            err_o <= enter_ack & acc_mis;
            if (enter_ack && !acc_write) data_o <= acc_mis ? 32'h0 : mem[acc_idx];
        end
    end

    // Array is not reset; the write is suppressed whenever reset is high at the edge.
    always_ff @(posedge clk_i) begin
        if (enter_ack && acc_write && !acc_mis && !rst_i) mem[acc_idx] <= acc_wdata;
    end
endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data-memory responder on the far side of the CPU's MEM-stage load/store interface. It replaces the single-cycle data memory with a word-organised array that answers each request after a fixed latency. It raises a stall toward the pipeline while a request is outstanding and pulses an acknowledge when the access completes. It sits between EX_MEM (address, store data, control) and MEM_WB (load data).

## Interface
- `DEPTH`, 256: number of 32-bit words; power of two.
- `LATENCY`, 4: cycles from acceptance to `ack_o`; legal range 1..15.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  1  request valid; held with `write_i`/`addr_i`/`data_i` stable until the cycle `ack_o` is high.
- `write_i`  in  1  1 = store word, 0 = load word.
- `addr_i`  in  32  byte address; word index = `addr_i[log2(DEPTH)+1:2]`, upper bits ignored.
- `data_i`  in  32  store data.
- `data_o`  out  32  load data; valid only while `ack_o`=1, otherwise holds its last value.
- `ack_o`  out  1  one-cycle completion pulse.
- `busy_o`  out  1  stall to PC/IF_ID/ID_EX/EX_MEM/MEM_WB write enables.
- `err_o`  out  1  misaligned-access flag, valid with `ack_o`.

## Operation
- FSM with three states: IDLE, WAIT, ACK. Latched request registers: `write_q`, `idx_q`, `wdata_q`, `mis_q`. A 4-bit down-counter `cnt`.
- IDLE: on `req_i`=1, latch the request and set `cnt`=LATENCY-1.
  - If LATENCY=1, go to ACK. Otherwise go to WAIT.
  - On `req_i`=0, stay in IDLE.
- WAIT: decrement `cnt`. When `cnt` reaches 1, the next state is ACK. Inputs are not resampled in WAIT.
- Edge entering ACK:
  - Store: `mem[idx_q]` <= `wdata_q`.
  - Load: `data_o` <= `mem[idx_q]`.
  - `ack_o` <= 1 and `err_o` <= `mis_q`.
- ACK: `ack_o`=1 for exactly one cycle, then return to IDLE unconditionally. `req_i` is ignored during ACK because it still carries the completed request.
- `busy_o` = (state==IDLE & `req_i`) | (state==WAIT). It is combinational, so the pipeline freezes in the cycle the request first appears. It is 0 in ACK, so the pipeline advances on the ACK edge.
- A load to the word being stored is not possible concurrently; there is only one outstanding request.
- Memory array is not reset. Contents are undefined until written, or preloaded by the bench via hierarchical `$readmemb`.

## Timing
- Request present in cycle 0 (IDLE) -> `ack_o` high in cycle LATENCY.
  - `busy_o` is high in cycles 0..LATENCY-1.
  - Total pipeline stall is LATENCY cycles.
- Back-to-back requests: ACK(cycle L) -> IDLE(cycle L+1) accepts the next request. Minimum spacing is LATENCY+1 cycles.
- Reset values:
  - state IDLE, `cnt`=0.
  - `ack_o`=0, `err_o`=0, `data_o`=32'h0.
  - `busy_o` follows `req_i` combinationally.
- Reset mid-operation (WAIT) aborts the request. No memory write occurs, since writes happen only on the ACK-entry edge. After release the block is in IDLE and re-accepts the still-asserted `req_i` as a new request.
- Reset asserted in the same cycle as the ACK-entry edge: reset wins, no write, no ack.
- Address wrap: indices beyond DEPTH alias modulo DEPTH.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - `mis_q` = (`addr_i[1:0]` != 0) at acceptance.
  - A misaligned store performs no write.
  - A misaligned load returns `data_o`=0.
  - Both complete with `ack_o`=1, `err_o`=1 after the normal LATENCY.
- Undefined: `addr_i[1:0]` is ignored (access rounds down to the word), `mis_q` is constant 0, and `err_o` is always 0.

## Test plan
- Reset, LATENCY=4: assert `rst_i` for 2 cycles with `req_i`=0 -> `ack_o`=0, `busy_o`=0, `data_o`=0.
- Store then load, LATENCY=4:
  - Store 32'hDEADBEEF to 0x10: `busy_o` high cycles 0–3, `ack_o` in cycle 4.
  - Load 0x10 from cycle 5: `ack_o` in cycle 9 with `data_o`=32'hDEADBEEF, `busy_o`=0 in cycle 9.
- LATENCY=1:
  - Load of preloaded word 3 (addr 0xC=32'h5) -> `busy_o` only in cycle 0, `ack_o` and `data_o`=5 in cycle 1.
  - Next request accepted in cycle 2.
- Reset mid-WAIT:
  - Store 32'h1234 to addr 0x20, pulse `rst_i` in cycle 2, then drop `req_i`.
  - Then load 0x20 -> returns the prior contents (preloaded 32'h0), never 32'h1234.
- Wrap, DEPTH=256: store 32'hA5 to addr 0x400 -> load addr 0x0 returns 32'hA5.
- Misaligned store 32'h77 to addr 0x22 (word 8 preloaded with 32'h11):
  - With `DMEM_ALIGN_CHECK_EN`: `ack_o`=1, `err_o`=1, word 8 stays 32'h11.
  - Without it: `err_o`=0, and a load of 0x20 returns 32'h77.
